// File: rtl/ep_cfg_sequencer_pkg.sv
// Shared types and layout constants for the endpoint-table configuration sequencer.
// Optional build macro: EP_CFG_LOCK_EN adds per-entry lock bits and the LOCK command.
package ep_cfg_sequencer_pkg;

   localparam int unsigned VADDR_BITS = 48;
   localparam int unsigned EP_CTRL_W  = 99;

   localparam int unsigned EP_VALID_OFFS  = 0;
   localparam int unsigned EP_RIGHTS_OFFS = 1;
   localparam int unsigned EP_BASE_OFFS   = 3;
   localparam int unsigned EP_BOUND_OFFS  = 51;

   typedef enum logic [1:0] {
      OpWrite    = 2'd0,
      OpInval    = 2'd1,
      OpInvalAll = 2'd2,
      OpLock     = 2'd3
   } ep_cfg_op_t;

   typedef enum logic [2:0] {
      StatOk         = 3'd0,
      StatErrIdx     = 3'd1,
      StatErrRange   = 3'd2,
      StatErrTimeout = 3'd3,
      StatErrLocked  = 3'd4
   } ep_cfg_status_t;

`ifdef EP_CFG_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   function automatic logic [EP_CTRL_W-1:0] pack_entry(input logic [VADDR_BITS-1:0] base,
                                                       input logic [VADDR_BITS-1:0] bound,
                                                       input logic [1:0]            rights);
      logic [EP_CTRL_W-1:0] e;
      e = '0;
      e[EP_VALID_OFFS]                     = 1'b1;
      e[EP_RIGHTS_OFFS +: 2]               = rights;
      e[EP_BASE_OFFS   +: VADDR_BITS]      = base;
      e[EP_BOUND_OFFS  +: VADDR_BITS]      = bound;
      return e;
   endfunction

endpackage

// File: rtl/ep_cfg_sequencer_table.sv
// Endpoint table registers: indexed write/clear, plus lock bits when EP_CFG_LOCK_EN is defined.
module ep_cfg_sequencer_table
   import ep_cfg_sequencer_pkg::*;
#(
   parameter int unsigned N_ENDPOINTS = 4,
   parameter int unsigned IDX_W       = 2
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic                               wr_en,
   input  logic                               clr_en,
   input  logic                               lock_set,
   input  logic [IDX_W-1:0]                   idx,
   input  logic [VADDR_BITS-1:0]              base,
   input  logic [VADDR_BITS-1:0]              bound,
   input  logic [1:0]                         rights,
   output logic [EP_CTRL_W*N_ENDPOINTS-1:0]   ep_ctrl,
   output logic [N_ENDPOINTS-1:0]             locked
);

   logic [EP_CTRL_W-1:0] entry_q [N_ENDPOINTS];

`ifdef EP_CFG_LOCK_EN
   logic [N_ENDPOINTS-1:0] lock_q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         lock_q <= '0;
      end else if (lock_set) begin
         for (int i = 0; i < N_ENDPOINTS; i++) begin
            if (idx == IDX_W'(i)) lock_q[i] <= 1'b1;
         end
      end
   end

   assign locked = lock_q;
`else
   logic unused_lock_set;
   assign unused_lock_set = lock_set;
   assign locked          = '0;
`endif

   // Clears never touch a locked entry, so a table sweep can run blindly over every index.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         entry_q <= '{default: '0};
      end else begin
         for (int i = 0; i < N_ENDPOINTS; i++) begin
            if (idx == IDX_W'(i)) begin
               if (wr_en) begin
                  entry_q[i] <= pack_entry(base, bound, rights);
               end else if (clr_en && !locked[i]) begin
                  entry_q[i] <= '0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < N_ENDPOINTS; g++) begin : g_pack
      assign ep_ctrl[g*EP_CTRL_W +: EP_CTRL_W] = entry_q[g];
   end

endmodule

// File: rtl/ep_cfg_sequencer.sv
// Sequences host table commands into the gateway endpoint table, holding and draining the
// request path around every commit. Honours EP_CFG_LOCK_EN through the package.
module ep_cfg_sequencer
   import ep_cfg_sequencer_pkg::*;
#(
   parameter int unsigned N_ENDPOINTS   = 4,
   parameter int unsigned IDX_W         = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1,
   parameter int unsigned DRAIN_TIMEOUT = 1024
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [1:0]                         cmd_op,
   input  logic [IDX_W-1:0]                   cmd_idx,
   input  logic [VADDR_BITS-1:0]              cmd_base,
   input  logic [VADDR_BITS-1:0]              cmd_bound,
   input  logic [1:0]                         cmd_rights,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [2:0]                         rsp_status,
   input  logic                               rd_pending,
   input  logic                               wr_pending,
   output logic                               gate_hold,
   output logic [EP_CTRL_W*N_ENDPOINTS-1:0]   ep_ctrl,
   output logic [15:0]                        cfg_epoch
);

   localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

   typedef enum logic [2:0] {StIdle, StCheck, StDrain, StCommit, StResp} state_t;

   state_t                state_q, state_d;
   ep_cfg_op_t            op_q, op_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VADDR_BITS-1:0] base_q, base_d;
   logic [VADDR_BITS-1:0] bound_q, bound_d;
   logic [1:0]            rights_q, rights_d;
   ep_cfg_status_t        status_q, status_d;
   logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
   logic [IDX_W-1:0]      sweep_q, sweep_d;
   logic [15:0]           epoch_q, epoch_d;

   logic                   tbl_wr, tbl_clr, tbl_lock, commit_done, target_locked;
   logic [IDX_W-1:0]       tbl_idx;
   logic [N_ENDPOINTS-1:0] locked;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= StIdle;
         op_q        <= OpWrite;
         idx_q       <= '0;
         base_q      <= '0;
         bound_q     <= '0;
         rights_q    <= '0;
         status_q    <= StatOk;
         drain_cnt_q <= '0;
         sweep_q     <= '0;
         epoch_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         base_q      <= base_d;
         bound_q     <= bound_d;
         rights_q    <= rights_d;
         status_q    <= status_d;
         drain_cnt_q <= drain_cnt_d;
         sweep_q     <= sweep_d;
         epoch_q     <= epoch_d;
      end
   end

   // cmd_idx may be wider than the table, so match indices explicitly.
   always_comb begin
      target_locked = 1'b0;
      for (int i = 0; i < N_ENDPOINTS; i++) begin
         if (idx_q == IDX_W'(i)) target_locked = locked[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      base_d      = base_q;
      bound_d     = bound_q;
      rights_d    = rights_q;
      status_d    = status_q;
      drain_cnt_d = drain_cnt_q;
      sweep_d     = sweep_q;
      epoch_d     = epoch_q;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      gate_hold   = 1'b0;
      tbl_wr      = 1'b0;
      tbl_clr     = 1'b0;
      tbl_lock    = 1'b0;
      tbl_idx     = idx_q;
      commit_done = 1'b1;

      unique case (state_q)
         StIdle: begin
            cmd_ready = !areset;
            if (cmd_valid) begin
               op_d     = ep_cfg_op_t'(cmd_op);
               idx_d    = cmd_idx;
               base_d   = cmd_base;
               bound_d  = cmd_bound;
               rights_d = cmd_rights;
               state_d  = StCheck;
            end
         end
         StCheck: begin
            state_d = StResp;
            if (!LOCK_EN && op_q == OpLock) begin
               status_d = StatErrRange;
            end else if (op_q != OpInvalAll && 32'(idx_q) >= N_ENDPOINTS) begin
               status_d = StatErrIdx;
            end else if (op_q == OpWrite && bound_q < base_q) begin
               status_d = StatErrRange;
            end else if (LOCK_EN && (op_q == OpWrite || op_q == OpInval) && target_locked) begin
               status_d = StatErrLocked;
            end else begin
               drain_cnt_d = '0;
               state_d     = StDrain;
            end
         end
         StDrain: begin
            gate_hold = 1'b1;
            if (!rd_pending && !wr_pending) begin
               sweep_d = '0;
               state_d = StCommit;
            end else if (drain_cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
               status_d = StatErrTimeout;
               state_d  = StResp;
            end else begin
               drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
         end
         StCommit: begin
            gate_hold = 1'b1;
            unique case (op_q)
               OpWrite: tbl_wr   = 1'b1;
               OpInval: tbl_clr  = 1'b1;
               OpLock:  tbl_lock = 1'b1;
               OpInvalAll: begin
                  tbl_clr = 1'b1;
                  tbl_idx = sweep_q;
                  if (sweep_q != IDX_W'(N_ENDPOINTS - 1)) begin
                     commit_done = 1'b0;
                     sweep_d     = sweep_q + IDX_W'(1);
                  end
               end
               default: ;
            endcase
            if (commit_done) begin
               epoch_d  = epoch_q + 16'd1;
               status_d = StatOk;
               state_d  = StResp;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign rsp_status = status_q;
   assign cfg_epoch  = epoch_q;

   ep_cfg_sequencer_table #(
      .N_ENDPOINTS (N_ENDPOINTS),
      .IDX_W       (IDX_W)
   ) u_table (
      .aclk     (aclk),
      .areset   (areset),
      .wr_en    (tbl_wr),
      .clr_en   (tbl_clr),
      .lock_set (tbl_lock),
      .idx      (tbl_idx),
      .base     (base_q),
      .bound    (bound_q),
      .rights   (rights_q),
      .ep_ctrl  (ep_ctrl),
      .locked   (locked)
   );

endmodule
